ifetch_ctrl: RTL and testbench
==============================

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h00400000, fetch address loaded on reset.
REQ-002 Parameter PC_STEP, default 4, sequential PC increment in bytes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imem_req  output  1  fetch request to instruction memory, level, held until acked.
REQ-006 imem_addr  output  32  word-aligned fetch address, stable while imem_req=1.
REQ-007 imem_ack  input  1  memory completes transfer in any cycle where imem_req&&imem_ack.
REQ-008 imem_rdata  input  32  instruction word, valid only in the ack cycle.
REQ-009 inst_valid  output  1  instruction register holds a deliverable instruction.
REQ-010 inst_out  output  32  instruction register contents.
REQ-011 inst_pc  output  32  address the instruction in inst_out was fetched from.
REQ-012 inst_ready  input  1  decoder accepts; handover when inst_valid&&inst_ready.
REQ-013 redirect_valid  input  1  one-cycle pulse: branch/jump/exception target present.
REQ-014 redirect_pc  input  32  target address; bits [1:0] ignored.
REQ-015 pc_out  output  32  next address to be fetched.

Function
REQ-016 FSM states: REQ (issue/hold fetch), HOLD (instruction waiting for decoder).
REQ-017 In REQ, imem_req=1 and imem_addr=pc every cycle, zero-cycle or multi-cycle ack latency tolerated.
REQ-018 On ack in REQ with no pending discard: inst_out<=imem_rdata, inst_pc<=pc, pc<=pc+PC_STEP, inst_valid<=1, state<=HOLD.
REQ-019 In HOLD, imem_req=0; on inst_ready, inst_valid<=0 and state<=REQ in the next cycle (one idle memory cycle between fetches).
REQ-020 Redirect in HOLD without inst_ready: instruction dropped (inst_valid<=0), pc<=redirect_pc & ~3, state<=REQ.
REQ-021 Redirect in HOLD with inst_ready same cycle: handover completes, pc<=redirect_pc & ~3, state<=REQ.
REQ-022 Redirect in REQ with ack same cycle: rdata discarded, inst_valid stays 0, pc<=redirect_pc & ~3, remain REQ.
REQ-023 Redirect in REQ without ack: request held to completion at the old address; target stored, discard flag set; pc_out shows target.
REQ-024 Ack while discard flag set: rdata dropped, pc<=stored target, flag cleared, remain REQ; imem_addr changes only after this ack.
REQ-025 Second redirect before the discarded ack overwrites the stored target; last redirect wins.
REQ-026 pc arithmetic 32-bit modulo: 32'hFFFFFFFC + 4 wraps to 32'h00000000; pc[1:0] always 2'b00.
REQ-027 inst_out and inst_pc hold their values whenever inst_valid=0 or no load occurs.

Reset
REQ-028 rst sampled on rising clk only; rst dominates redirect, ack and inst_ready in the same cycle.
REQ-029 Reset values: pc=RESET_PC, state=REQ, inst_valid=0, inst_out=0, inst_pc=0, discard flag=0.
REQ-030 First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.
REQ-031 Reset mid-handshake abandons the request; memory side ignores any ack during rst.

Structure
REQ-032 Shared package cpu_pkg holds RESET_PC default, PC_STEP, 32-bit word width constant, and fetch state enum.
REQ-033 No sub-module; PC register, instruction register, discard flag and FSM live in ifetch_ctrl.

Verification
REQ-034 Reset then ack every REQ cycle, inst_ready=1: imem_addr 0x00400000, 0x00400004, 0x00400008; inst_pc matches; one idle cycle per fetch.
REQ-035 Ack delayed 3 cycles: imem_req and imem_addr=0x00400000 stable 4 cycles; instruction delivered once.
REQ-036 inst_ready=0 for 5 cycles in HOLD: inst_valid, inst_out stable, imem_req=0; pc_out=0x00400004.
REQ-037 Redirect to 0x00400103 while ack outstanding at 0x00400004: old data dropped, next imem_addr=0x00400100, inst_valid never set for 0x00400004.
REQ-038 pc=0xFFFFFFFC fetched via redirect: next imem_addr=0x00000000.
REQ-039 rst asserted during REQ with ack same cycle: inst_valid=0, next imem_addr=0x00400000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and the instruction-fetch state encoding.
// Imported by the fetch controller and its bus interface.
package cpu_pkg;

   localparam int unsigned WORD_W = 32;

   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0040_0000;
   localparam int unsigned       PC_STEP_DEFAULT  = 4;

   // Fetch addresses are always word aligned; the low two bits are forced to zero.
   localparam logic [WORD_W-1:0] PC_ALIGN_MASK = ~32'h0000_0003;

   typedef enum logic [0:0] {
      ST_REQ  = 1'b0,
      ST_HOLD = 1'b1
   } fetch_state_e;

   function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] addr);
      return addr & PC_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Signal bundle between the fetch controller, instruction memory, decoder and
// redirect source. The master side is the fetch controller.
//
// Handshake rules (both channels are level, valid/ready style):
//   imem:  imem_req stays high with a stable imem_addr until the cycle where
//          imem_req && imem_ack; imem_rdata is meaningful only in that cycle.
//   inst:  inst_valid stays high with stable inst_out/inst_pc until the cycle
//          where inst_valid && inst_ready; that cycle is the handover.
//   redirect_valid is a one-cycle pulse qualifying redirect_pc.
interface ifetch_ctrl_if;
   import cpu_pkg::*;

   logic              imem_req;
   logic [WORD_W-1:0] imem_addr;
   logic              imem_ack;
   logic [WORD_W-1:0] imem_rdata;

   logic              inst_valid;
   logic [WORD_W-1:0] inst_out;
   logic [WORD_W-1:0] inst_pc;
   logic              inst_ready;

   logic              redirect_valid;
   logic [WORD_W-1:0] redirect_pc;

   logic [WORD_W-1:0] pc_out;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata,
      output inst_valid,
      output inst_out,
      output inst_pc,
      input  inst_ready,
      input  redirect_valid,
      input  redirect_pc,
      output pc_out
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata,
      input  inst_valid,
      input  inst_out,
      input  inst_pc,
      output inst_ready,
      output redirect_valid,
      output redirect_pc,
      input  pc_out
   );

endinterface

// File: rtl/ifetch_ctrl.sv
// Single-entry instruction fetch controller: issues one fetch at a time, parks
// the result for the decoder, and handles redirects including in-flight discard.
module ifetch_ctrl
   import cpu_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned       PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   ifetch_ctrl_if.master bus,
   output fetch_state_e  dbg_state_o
);

   fetch_state_e      state_q,    state_d;
   logic [WORD_W-1:0] pc_q,       pc_d;
   logic [WORD_W-1:0] inst_q,     inst_d;
   logic [WORD_W-1:0] inst_pc_q,  inst_pc_d;
   logic              valid_q,    valid_d;
   logic              discard_q,  discard_d;
   logic [WORD_W-1:0] target_q,   target_d;

   logic [WORD_W-1:0] pc_seq;
   logic [WORD_W-1:0] redirect_aligned;
   logic              fetch_done;

   assign pc_seq           = align_pc(pc_q + WORD_W'(PC_STEP));
   assign redirect_aligned = align_pc(bus.redirect_pc);
   assign fetch_done       = (state_q == ST_REQ) && bus.imem_ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_REQ;
         pc_q      <= align_pc(RESET_PC);
         inst_q    <= '0;
         inst_pc_q <= '0;
         valid_q   <= 1'b0;
         discard_q <= 1'b0;
         target_q  <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         valid_q   <= valid_d;
         discard_q <= discard_d;
         target_q  <= target_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      valid_d   = valid_q;
      discard_d = discard_q;
      target_d  = target_q;

      case (state_q)
         ST_REQ: begin
            if (fetch_done) begin
               if (bus.redirect_valid) begin
                  // A redirect in the completing cycle supersedes both this
                  // data and any target stored by an earlier redirect.
                  pc_d      = redirect_aligned;
                  discard_d = 1'b0;
               end else if (discard_q) begin
                  pc_d      = target_q;
                  discard_d = 1'b0;
               end else begin
                  inst_d    = bus.imem_rdata;
                  inst_pc_d = pc_q;
                  pc_d      = pc_seq;
                  valid_d   = 1'b1;
                  state_d   = ST_HOLD;
               end
            end else if (bus.redirect_valid) begin
               // Request must complete at the old address; remember where to go.
               target_d  = redirect_aligned;
               discard_d = 1'b1;
            end
         end

         ST_HOLD: begin
            if (bus.inst_ready || bus.redirect_valid) begin
               valid_d = 1'b0;
               state_d = ST_REQ;
            end
            if (bus.redirect_valid) begin
               pc_d = redirect_aligned;
            end
         end

         default: begin
            state_d = ST_REQ;
         end
      endcase
   end

   assign bus.imem_req   = (state_q == ST_REQ);
   assign bus.imem_addr  = pc_q;
   assign bus.inst_valid = valid_q;
   assign bus.inst_out   = inst_q;
   assign bus.inst_pc    = inst_pc_q;
   assign bus.pc_out     = discard_q ? target_q : pc_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: hand-computed expectations for sequential
// fetch, ack latency, decoder stall, redirects, PC wrap and reset.
module tb_ifetch_ctrl;
   import cpu_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   fetch_state_e dbg_state;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   ifetch_ctrl_if bus ();

   ifetch_ctrl #(
      .RESET_PC (32'h0040_0000),
      .PC_STEP  (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.master),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ack, input logic [31:0] rdata, input logic ready,
                        input logic rv, input logic [31:0] rpc);
      bus.imem_ack       = ack;
      bus.imem_rdata     = rdata;
      bus.inst_ready     = ready;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      // Reset values and first cycle after reset
      do_reset();
      check("rst_valid",    32'(bus.inst_valid), 32'd0);
      check("rst_inst_out", bus.inst_out,        32'h0);
      check("rst_inst_pc",  bus.inst_pc,         32'h0);
      check("rst_pc_out",   bus.pc_out,          32'h0040_0000);
      check("rst_state",    32'(dbg_state),      32'(ST_REQ));
      check("rst_req",      32'(bus.imem_req),   32'd1);
      check("rst_addr",     bus.imem_addr,       32'h0040_0000);

      // Back-to-back fetch with immediate ack and ready decoder
      drive(1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h0);
      step();
      check("seq0_valid",   32'(bus.inst_valid), 32'd1);
      check("seq0_inst",    bus.inst_out,        32'h1111_1111);
      check("seq0_pc",      bus.inst_pc,         32'h0040_0000);
      check("seq0_idle",    32'(bus.imem_req),   32'd0);
      step();
      check("seq1_addr",    bus.imem_addr,       32'h0040_0004);
      check("seq1_novalid", 32'(bus.inst_valid), 32'd0);
      drive(1'b1, 32'h2222_2222, 1'b1, 1'b0, 32'h0);
      step();
      check("seq1_pc",      bus.inst_pc,         32'h0040_0004);
      check("seq1_inst",    bus.inst_out,        32'h2222_2222);
      step();
      check("seq2_addr",    bus.imem_addr,       32'h0040_0008);
      drive(1'b1, 32'h3333_3333, 1'b1, 1'b0, 32'h0);
      step();
      check("seq2_pc",      bus.inst_pc,         32'h0040_0008);
      check("seq2_pcout",   bus.pc_out,          32'h0040_000C);

      // Ack delayed three cycles, then decoder stalls five cycles
      do_reset();
      for (int i = 0; i < 3; i++) begin
         check("lat_req",  32'(bus.imem_req), 32'd1);
         check("lat_addr", bus.imem_addr,     32'h0040_0000);
         step();
      end
      check("lat_req4",  32'(bus.imem_req), 32'd1);
      check("lat_addr4", bus.imem_addr,     32'h0040_0000);
      drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 32'h0);
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 32'(bus.inst_valid), 32'd1);
         check("stall_inst",  bus.inst_out,        32'hAAAA_0001);
         check("stall_req",   32'(bus.imem_req),   32'd0);
         check("stall_pcout", bus.pc_out,          32'h0040_0004);
         step();
      end
      bus.inst_ready = 1'b1;
      step();
      check("once_valid", 32'(bus.inst_valid), 32'd0);
      check("once_addr",  bus.imem_addr,       32'h0040_0004);

      // Redirect while fetch at 0x00400004 is outstanding
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0103);
      step();
      bus.redirect_valid = 1'b0;
      check("disc_hold_addr", bus.imem_addr, 32'h0040_0004);
      check("disc_pcout",     bus.pc_out,    32'h0040_0100);
      step();
      check("disc_hold_addr2", bus.imem_addr, 32'h0040_0004);
      drive(1'b1, 32'hDEAD_0004, 1'b1, 1'b0, 32'h0);
      step();
      bus.imem_ack = 1'b0;
      check("disc_novalid", 32'(bus.inst_valid), 32'd0);
      check("disc_inst",    bus.inst_out,        32'hAAAA_0001);
      check("disc_addr",    bus.imem_addr,       32'h0040_0100);
      check("disc_req",     32'(bus.imem_req),   32'd1);
      drive(1'b1, 32'hBEEF_0100, 1'b1, 1'b0, 32'h0);
      step();
      bus.imem_ack = 1'b0;
      check("tgt_valid", 32'(bus.inst_valid), 32'd1);
      check("tgt_pc",    bus.inst_pc,         32'h0040_0100);
      check("tgt_inst",  bus.inst_out,        32'hBEEF_0100);
      step();
      check("tgt_next", bus.imem_addr, 32'h0040_0104);

      // Two redirects before the discarded ack: the later one wins
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0050_0000);
      step();
      bus.redirect_pc = 32'h0060_0009;
      step();
      bus.redirect_valid = 1'b0;
      check("last_pcout", bus.pc_out,    32'h0060_0008);
      check("last_hold",  bus.imem_addr, 32'h0040_0104);
      drive(1'b1, 32'h9999_9999, 1'b1, 1'b0, 32'h0);
      step();
      bus.imem_ack = 1'b0;
      check("last_addr",  bus.imem_addr,       32'h0060_0008);
      check("last_valid", 32'(bus.inst_valid), 32'd0);

      // Redirect in HOLD without ready drops the instruction; PC wraps
      drive(1'b1, 32'h1234_0608, 1'b0, 1'b0, 32'h0);
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE);
      step();
      bus.redirect_valid = 1'b0;
      check("drop_valid", 32'(bus.inst_valid), 32'd0);
      check("drop_addr",  bus.imem_addr,       32'hFFFF_FFFC);
      check("drop_state", 32'(dbg_state),      32'(ST_REQ));
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'h0F0F_0F0F;
      step();
      bus.imem_ack = 1'b0;
      check("wrap_pc",    bus.inst_pc, 32'hFFFF_FFFC);
      check("wrap_pcout", bus.pc_out,  32'h0000_0000);
      bus.inst_ready = 1'b1;
      step();
      check("wrap_addr", bus.imem_addr, 32'h0000_0000);

      // Redirect in HOLD with ready in the same cycle
      drive(1'b1, 32'h5555_0000, 1'b0, 1'b0, 32'h0);
      step();
      check("hr_pc", bus.inst_pc, 32'h0000_0000);
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0020);
      step();
      bus.redirect_valid = 1'b0;
      check("hr_valid", 32'(bus.inst_valid), 32'd0);
      check("hr_addr",  bus.imem_addr,       32'h0040_0020);

      // Redirect coincident with ack in REQ
      drive(1'b1, 32'h6666_6666, 1'b1, 1'b1, 32'h0040_0043);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      check("ra_valid", 32'(bus.inst_valid), 32'd0);
      check("ra_addr",  bus.imem_addr,       32'h0040_0040);
      check("ra_state", 32'(dbg_state),      32'(ST_REQ));
      check("ra_inst",  bus.inst_out,        32'h5555_0000);

      // Reset dominates an ack in the same cycle
      rst = 1'b1;
      drive(1'b1, 32'h7777_7777, 1'b1, 1'b1, 32'h0080_0000);
      step();
      rst = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("ra_rst_valid", 32'(bus.inst_valid), 32'd0);
      check("ra_rst_inst",  bus.inst_out,        32'h0);
      check("ra_rst_addr",  bus.imem_addr,       32'h0040_0000);
      check("ra_rst_req",   32'(bus.imem_req),   32'd1);
      step();
      check("ra_rst_hold", bus.imem_addr, 32'h0040_0000);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
